// File: rtl/lcd1602_text_driver.sv
// lcd1602_text_driver: autonomous HD44780 8-bit writer that initialises the panel and prints two fixed lines.
// All pin activity is paced by a tick from a COUNT_MAX-cycle divider.
module lcd1602_text_driver #(
    parameter int COUNT_MAX       = 100000,
    parameter int INIT_WAIT_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    output logic       rs,
    output logic       rw,
    output logic       enable,
    output logic [7:0] data
);
    localparam int CW = $clog2(COUNT_MAX);
    // All 39 bytes in send order, first byte in the MSBs; rs flag per byte likewise.
    localparam logic [311:0] ROM = {40'h38_08_01_06_0C, 8'h80, "HELLO WORLD     ", 8'hC0, "LCD1602 READY   "};
    localparam logic [38:0] RS_ROM = {6'b0, {16{1'b1}}, 1'b0, {16{1'b1}}};

    typedef enum logic [2:0] {WAIT, INIT, LINE1, LINE2, DONE} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    state_t        state;
    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [15:0]   wait_cnt;
    logic [5:0]    idx;
    logic [5:0]    ridx;
    logic          tick;

    assign tick = cnt == CW'(COUNT_MAX - 1);
    assign ridx = 6'd38 - idx;
    assign rw   = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            state    <= WAIT;
            phase    <= SETUP;
            rs       <= 1'b0;
            enable   <= 1'b0;
            data     <= 8'h00;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                if (state == WAIT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == 16'(INIT_WAIT_TICKS - 1))
                        state <= INIT;
                end else if (state != DONE) begin
                    case (phase)
                        SETUP: begin
                            rs    <= RS_ROM[ridx];
                            data  <= ROM[{ridx, 3'b000} +: 8];
                            phase <= PULSE;
                        end
                        PULSE: begin
                            enable <= 1'b1;
                            phase  <= HOLD;
                        end
                        default: begin
                            enable <= 1'b0;
                            phase  <= SETUP;
                            idx    <= idx + 1'b1;
                            if (idx == 6'd4)
                                state <= LINE1;
                            else if (idx == 6'd21)
                                state <= LINE2;
                            else if (idx == 6'd38)
                                state <= DONE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd1602_text_driver.sv
// tb_lcd1602_text_driver: watches the LCD pins and compares every strobe against the expected byte stream.
// Timing is measured in clocks between pin events; reset points are randomized.
module tb_lcd1602_text_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rs, rw, enable;
    logic [7:0] data;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_data[$];
    logic       exp_rs[$];

    lcd1602_text_driver #(.COUNT_MAX(8), .INIT_WAIT_TICKS(20)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_text(input string s, input logic [7:0] cmd);
        exp_data.push_back(cmd);
        exp_rs.push_back(1'b0);
        for (int i = 0; i < s.len(); i++) begin
            exp_data.push_back(s[i]);
            exp_rs.push_back(1'b1);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear without any edge.
    task automatic hit_reset(input string tag);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check({tag, "_rs"}, rs, 0);
        check({tag, "_rw"}, rw, 0);
        check({tag, "_en"}, enable, 0);
        check({tag, "_data"}, data, 8'h00);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic watch(input int stop_at, input int budget, output int seen);
        int c, last_chg, last_rise, fall_t;
        logic prev_en;
        logic [8:0] prev_bus;
        seen = 0; c = 0; last_chg = 0; last_rise = 0; fall_t = -1;
        prev_en = enable;
        prev_bus = {rs, data};
        while (seen < stop_at && c < budget) begin
            @(negedge clk);
            c++;
            if ({rs, data} !== prev_bus) begin
                check("bus_change_near_e", {30'd0, enable, prev_en}, 0);
                if (fall_t >= 0) check("hold_after_fall", c - fall_t >= 8, 1);
                last_chg = c;
                prev_bus = {rs, data};
            end
            if (enable && !prev_en) begin
                if (seen == 0) check("wait_len", c > 160, 1);
                else check("rise_gap", c - last_rise, 24);
                check("setup_time", c - last_chg >= 8, 1);
                check($sformatf("rs[%0d]", seen), rs, exp_rs[seen]);
                check($sformatf("data[%0d]", seen), data, exp_data[seen]);
                check("rw", rw, 0);
                last_rise = c;
                seen++;
            end
            if (!enable && prev_en) begin
                check("pulse_width", c - last_rise, 8);
                fall_t = c;
            end
            prev_en = enable;
        end
        check("pulse_count", seen, stop_at);
    endtask

    initial begin
        int seen, extra, stop;
        logic prev_en;
        push_text("", 8'h38);
        push_text("", 8'h08);
        push_text("", 8'h01);
        push_text("", 8'h06);
        push_text("", 8'h0C);
        push_text("HELLO WORLD     ", 8'h80);
        push_text("LCD1602 READY   ", 8'hC0);
        repeat (3) @(negedge clk);
        check("por_en", enable, 0);
        check("por_data", data, 8'h00);
        reset = 1'b0;
        // Run partway into the sequence, then reset asynchronously mid-run.
        repeat ($urandom_range(300, 900)) @(negedge clk);
        hit_reset("mid_reset");
        // Abort somewhere inside LINE1 and restart.
        stop = $urandom_range(7, 21);
        watch(stop, 2000, seen);
        hit_reset("line1_reset");
        watch(39, 2000, seen);
        extra = 0;
        prev_en = enable;
        repeat (400) begin
            @(negedge clk);
            if (enable && !prev_en) extra++;
            check("rw_idle", rw, 0);
            prev_en = enable;
        end
        check("extra_pulses", extra, 0);
        check("done_en", enable, 0);
        check("done_rs", rs, 1);
        check("done_data", data, 8'h20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
